// File: rtl/rv_pwmcap_if.sv
// CPU local-bus register port shared by the rv_io peripherals.
interface rv_pwmcap_if;
  logic [4:0]  adr;
  logic        cs;
  logic        rdy;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic [31:0] dr;

  modport master (output adr, cs, rdy, we, re, dw, input dr);
  modport slave  (input adr, cs, rdy, we, re, dw, output dr);
endinterface

// File: rtl/rv_pwmcap.sv
// Four-channel pulse-width/period capture: each channel latches HIGH/PERIOD
// (in prescaled ticks) between consecutive rising edges of its input.
module rv_pwmcap #(
  parameter int unsigned NCH       = 4,
  parameter logic [11:0] PRESC_RST = 12'd59
) (
  input  logic           clk,
  input  logic           xreset,
  rv_pwmcap_if.slave     bus,
  input  logic [NCH-1:0] cap_in,
  output logic           irq
);
  localparam logic [1:0] ST_DIS  = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  logic [NCH-1:0]       en_q, en_d, ien_q, ien_d;
  logic [NCH-1:0]       valid_q, valid_d, ovf_q, ovf_d;
  logic [11:0]          presc_q, presc_d, precnt_q, precnt_d;
  logic [NCH-1:0]       s1_q, s2_q, prv_q;
  logic [NCH-1:0][1:0]  st_q, st_d;
  logic [NCH-1:0][15:0] cnt_q, cnt_d, hsh_q, hsh_d, per_q, per_d, hi_q, hi_d;
  logic [31:0]          dr_q, dr_d, rdata;
  logic                 irq_q, irq_d;
  logic [NCH-1:0]       rise, fall, set_valid, set_ovf, clr_valid, clr_ovf;
  logic [2:0]           sel;
  logic                 wr_en, rd_en, presc_wr, tick;
  logic                 unused_bus;

  assign sel        = bus.adr[4:2];
  assign wr_en      = bus.cs & bus.rdy & (|bus.we);
  assign rd_en      = bus.cs & bus.re & bus.rdy;
  assign presc_wr   = wr_en && (sel == 3'd6);
  assign tick       = (precnt_q == presc_q);
  assign rise       = s2_q & ~prv_q;
  assign fall       = ~s2_q & prv_q;
  assign bus.dr     = dr_q;
  assign irq        = irq_q;
  assign unused_bus = ^{bus.adr[1:0], bus.dw[31:12], bus.we[3:2]};

  always_comb begin
    en_d      = en_q;
    ien_d     = ien_q;
    presc_d   = presc_q;
    clr_valid = '0;
    clr_ovf   = '0;
    if (wr_en) begin
      case (sel)
        3'd0: if (bus.we[0]) begin
          en_d  = bus.dw[NCH-1:0];
          ien_d = bus.dw[4 +: NCH];
        end
        3'd1: begin
          if (bus.we[0]) clr_valid = bus.dw[NCH-1:0];
          if (bus.we[1]) clr_ovf   = bus.dw[8 +: NCH];
        end
        3'd6: begin
          if (bus.we[0]) presc_d[7:0]  = bus.dw[7:0];
          if (bus.we[1]) presc_d[11:8] = bus.dw[11:8];
        end
        default: ;
      endcase
    end
    precnt_d = (presc_wr || tick) ? '0 : precnt_q + 12'd1;
  end

  always_comb begin
    logic [16:0] inc;
    st_d      = st_q;
    cnt_d     = cnt_q;
    hsh_d     = hsh_q;
    per_d     = per_q;
    hi_d      = hi_q;
    set_valid = '0;
    set_ovf   = '0;
    inc       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      inc = {1'b0, cnt_q[i]} + {16'b0, tick};
      case (st_q[i])
        ST_DIS: begin
          cnt_d[i] = '0;
          if (en_q[i]) st_d[i] = ST_ARM;
        end
        ST_ARM: if (rise[i]) begin
          cnt_d[i] = '0;
          hsh_d[i] = '0;
          st_d[i]  = ST_MEAS;
        end
        ST_MEAS: begin
          // Overflow takes priority: a count past 0xFFFF cannot be reported.
          if (inc[16]) begin
            set_ovf[i] = 1'b1;
            cnt_d[i]   = '0;
            st_d[i]    = ST_ARM;
          end else if (rise[i]) begin
            per_d[i]     = inc[15:0];
            hi_d[i]      = hsh_q[i];
            set_valid[i] = 1'b1;
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = inc[15:0];
            if (fall[i]) hsh_d[i] = inc[15:0];
          end
        end
        default: st_d[i] = ST_DIS;
      endcase
      if (!en_q[i]) st_d[i] = ST_DIS;
    end
    // A capture in the same clock as a W1C wins, so no event is lost.
    valid_d = (valid_q & ~clr_valid) | set_valid;
    ovf_d   = (ovf_q & ~clr_ovf) | set_ovf;
    irq_d   = |(valid_q & ien_q);
  end

  always_comb begin
    rdata = '0;
    case (sel)
      3'd0: begin
        rdata[NCH-1:0] = en_q;
        rdata[4 +: NCH] = ien_q;
      end
      3'd1: begin
        rdata[NCH-1:0] = valid_q;
        rdata[8 +: NCH] = ovf_q;
      end
      3'd6: rdata[11:0] = presc_q;
      default: begin
        for (int unsigned i = 0; i < NCH; i++)
          if (sel == 3'(i + 2)) rdata = {hi_q[i], per_q[i]};
      end
    endcase
    dr_d = dr_q;
    if (bus.rdy) dr_d = rd_en ? rdata : '0;
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      en_q     <= '0;
      ien_q    <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      presc_q  <= PRESC_RST;
      precnt_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      prv_q    <= '0;
      st_q     <= {NCH{ST_DIS}};
      cnt_q    <= '0;
      hsh_q    <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      dr_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      ien_q    <= ien_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      precnt_q <= precnt_d;
      s1_q     <= cap_in;
      s2_q     <= s1_q;
      prv_q    <= s2_q;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      hsh_q    <= hsh_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      dr_q     <= dr_d;
      irq_q    <= irq_d;
    end
  end
endmodule

// File: tb/tb_rv_pwmcap.sv
// Directed bench for rv_pwmcap: register access, capture, overflow, W1C and reset.
module tb_rv_pwmcap;
  logic       clk;
  logic       xreset;
  logic [3:0] cap_in;
  logic       irq;
  logic [31:0] d;
  int checks;
  int failures;

  rv_pwmcap_if bus ();

  rv_pwmcap #(.NCH(4), .PRESC_RST(12'd59)) dut (
    .clk    (clk),
    .xreset (xreset),
    .bus    (bus),
    .cap_in (cap_in),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] w, input logic [31:0] v);
    bus.adr = a;
    bus.we  = w;
    bus.dw  = v;
    bus.cs  = 1'b1;
    @(posedge clk);
    #1;
    bus.cs = 1'b0;
    bus.we = 4'h0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus.adr = a;
    bus.cs  = 1'b1;
    bus.re  = 1'b1;
    @(posedge clk);
    #1;
    bus.cs = 1'b0;
    bus.re = 1'b0;
    v = bus.dr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    xreset   = 1'b0;
    cap_in   = 4'h0;
    bus.adr  = '0;
    bus.cs   = 1'b0;
    bus.rdy  = 1'b1;
    bus.we   = 4'h0;
    bus.re   = 1'b0;
    bus.dw   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dr", bus.dr, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    xreset = 1'b1;
    cyc(1);
    rd(5'd0, d);  chk("reset_ctrl", d, 32'h0);
    rd(5'd4, d);  chk("reset_status", d, 32'h0);
    rd(5'd8, d);  chk("reset_ch0", d, 32'h0);
    rd(5'd24, d); chk("reset_presc", d, 32'd59);

    // CH0 10 high / 30 low at PRESC=0; CH1 pulses once then stays low.
    wr(5'd24, 4'h3, 32'h0);
    wr(5'd0, 4'h1, 32'h3);
    for (int i = 0; i < 100; i++) begin
      cap_in[0] = (i % 40) < 10;
      cap_in[1] = i < 3;
      cyc(1);
    end
    rd(5'd8, d);  chk("ch0_capture", d, 32'h000A_0028);
    rd(5'd4, d);  chk("ch0_valid", d, 32'h0000_0001);
    wr(5'd0, 4'h1, 32'h2);
    cyc(65600);
    rd(5'd4, d);  chk("ch1_ovf_status", d, 32'h0000_0201);
    rd(5'd12, d); chk("ch1_unchanged", d, 32'h0);
    cap_in[1] = 1'b1; cyc(5);
    cap_in[1] = 1'b0; cyc(15);
    cap_in[1] = 1'b1; cyc(5);
    cap_in[1] = 1'b0; cyc(6);
    rd(5'd12, d); chk("ch1_recapture", d, 32'h0005_0014);
    rd(5'd4, d);  chk("ch1_valid", d, 32'h0000_0203);
    wr(5'd0, 4'h1, 32'h0);
    wr(5'd4, 4'hF, 32'hFFFF_FFFF);
    rd(5'd4, d);  chk("w1c_all", d, 32'h0);

    // CH2: 4000-clk period, 25% duty, tick every 4 clocks.
    wr(5'd24, 4'h3, 32'd3);
    wr(5'd0, 4'h1, 32'h44);
    for (int i = 0; i < 5000; i++) begin
      cap_in[2] = (i % 4000) < 1000;
      cyc(1);
    end
    rd(5'd16, d); chk("ch2_capture", d, 32'h00FA_03E8);
    rd(5'd4, d);  chk("ch2_valid", d, 32'h0000_0004);
    chk("ch2_irq_set", {31'b0, irq}, 32'h1);
    wr(5'd4, 4'h1, 32'h4);
    chk("ch2_irq_lag", {31'b0, irq}, 32'h1);
    cyc(1);
    chk("ch2_irq_clear", {31'b0, irq}, 32'h0);

    // CH3: W1C of valid3 lands on the same clock as a capture.
    wr(5'd24, 4'h3, 32'h0);
    wr(5'd0, 4'h1, 32'h08);
    cap_in[3] = 1'b1; cyc(4);
    cap_in[3] = 1'b0; cyc(4);
    cap_in[3] = 1'b1; cyc(4);
    cap_in[3] = 1'b0; cyc(4);
    cap_in[3] = 1'b1; cyc(2);
    wr(5'd4, 4'h1, 32'h8);
    rd(5'd4, d);  chk("ch3_set_wins", d, 32'h0000_0008);
    rd(5'd20, d); chk("ch3_capture", d, 32'h0004_0008);

    // Byte lanes, unmapped address, rdy gating.
    wr(5'd0, 4'hF, 32'h50);
    wr(5'd0, 4'hE, 32'hFFFF_FFFF);
    rd(5'd0, d);  chk("ctrl_upper_lanes", d, 32'h50);
    wr(5'd0, 4'h1, 32'hFFFF_FFFF);
    rd(5'd28, d); chk("addr7_zero", d, 32'h0);
    rd(5'd0, d);  chk("ctrl_lane0", d, 32'hFF);
    cyc(1);
    chk("dr_idle_zero", bus.dr, 32'h0);
    rd(5'd0, d);
    bus.rdy = 1'b0;
    bus.cs  = 1'b1;
    bus.adr = 5'd0;
    bus.we  = 4'hF;
    bus.dw  = 32'h0;
    cyc(3);
    bus.cs = 1'b0;
    bus.we = 4'h0;
    chk("rdy_low_hold", bus.dr, 32'hFF);
    bus.rdy = 1'b1;
    rd(5'd0, d);  chk("rdy_low_nowrite", d, 32'hFF);
    chk("irq_ch3", {31'b0, irq}, 32'h1);

    // Asynchronous reset in the middle of a measurement.
    cap_in = 4'hF; cyc(5);
    cap_in = 4'h0; cyc(3);
    rd(5'd0, d);
    bus.rdy = 1'b0;
    #3 xreset = 1'b0;
    #1;
    chk("async_rst_dr", bus.dr, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    cyc(2);
    xreset  = 1'b1;
    bus.rdy = 1'b1;
    cyc(1);
    rd(5'd4, d);  chk("post_rst_status", d, 32'h0);
    rd(5'd24, d); chk("post_rst_presc", d, 32'd59);
    rd(5'd0, d);  chk("post_rst_ctrl", d, 32'h0);
    rd(5'd8, d);  chk("post_rst_ch0", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
